// File: rtl/mux_result_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : mux_pipe_pkg
//  Description: Shared types and defaults for the mux result pipeline stage:
//               data width, buffer occupancy states and the buffered beat.
//  Revision   : 1.0 - initial release
// ============================================================================
package mux_pipe_pkg;

    // Width of the Multiplexer21 C output.
    localparam int DEF_DATA_W = 72;

    // Default width of the per-source delivery counters.
    localparam int DEF_CNT_W  = 16;

    // Buffer occupancy: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One buffered beat: the mux result together with the select that made it.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  sel;
    } beat_t;

endpackage : mux_pipe_pkg
`default_nettype wire

// File: rtl/mux_result_skid_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface  : mux_result_skid_buffer_if
//  Description: Upstream and downstream valid/ready handshake of the mux
//               result skid buffer, plus the synchronous flush request.
//               slave  : the buffer itself.
//               master : the environment driving it.
//  Revision   : 1.0 - initial release
// ============================================================================
interface mux_result_skid_buffer_if #(
    parameter int DATA_W = mux_pipe_pkg::DEF_DATA_W
);

    // Upstream side (mux output into the buffer)
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic              inSel;

    // Discard everything held in the buffer
    logic              flush;

    // Downstream side (buffer into the next stage)
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic              outSel;

    modport slave (
        input  inValid,
        input  inData,
        input  inSel,
        input  flush,
        input  outReady,
        output inReady,
        output outValid,
        output outData,
        output outSel
    );

    modport master (
        output inValid,
        output inData,
        output inSel,
        output flush,
        output outReady,
        input  inReady,
        input  outValid,
        input  outData,
        input  outSel
    );

endinterface : mux_result_skid_buffer_if
`default_nettype wire

// File: rtl/mux_result_skid_buffer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module     : sat_counter
//  Description: Up-counter that sticks at its all-ones value instead of
//               wrapping. Used for per-source delivery statistics.
//  Revision   : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clock,
    input  wire logic             resetN,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_value;
    logic             w_atMax;

    assign w_atMax = (r_value == c_MAX);
    assign value   = r_value;

    // Count requested events, holding once the maximum is reached.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_value <= '0;
        end else if (inc && !w_atMax) begin
            r_value <= r_value + c_ONE;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mux_result_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module     : mux_result_skid_buffer
//  Description: Registered stage after the 72-bit 2:1 operand mux. Holds the
//               mux result with its source tag in a 2-entry skid buffer
//               (main + skid register) so that inReady is a pure function of
//               registered state and throughput stays at one beat per cycle.
//               Two saturating counters tally beats delivered per source.
//  Revision   : 1.0 - initial release
// ============================================================================
module mux_result_skid_buffer
    import mux_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,  // must equal DEF_DATA_W (beat storage width)
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic                   clock,
    input  wire logic                   resetN,
    mux_result_skid_buffer_if.slave     bus,
    output logic      [CNT_W-1:0]       cntA,
    output logic      [CNT_W-1:0]       cntB
);

    // ------------------------------------------------------------------
    //  State and storage
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_stateNext;

    beat_t  r_main;     // head of the queue, always what downstream sees
    beat_t  r_skid;     // second beat, caught while downstream stalls
    beat_t  w_inBeat;

    logic   w_inReady;
    logic   w_outValid;
    logic   w_inXfer;
    logic   w_outXfer;

    logic   w_loadMainIn;
    logic   w_loadMainSkid;
    logic   w_loadSkid;

    // ------------------------------------------------------------------
    //  Handshake decode - both ready and valid come from r_state only,
    //  so there is no combinational path from outReady to inReady.
    // ------------------------------------------------------------------
    assign w_inReady  = (r_state != FULL);
    assign w_outValid = (r_state != EMPTY);

    assign w_inXfer   = bus.inValid  && w_inReady;
    assign w_outXfer  = w_outValid   && bus.outReady;

    assign w_inBeat   = '{data: bus.inData, sel: bus.inSel};

    assign bus.inReady  = w_inReady;
    assign bus.outValid = w_outValid;
    assign bus.outData  = r_main.data;
    assign bus.outSel   = r_main.sel;

    // ------------------------------------------------------------------
    //  FSM
    // ------------------------------------------------------------------

    // Occupancy register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next occupancy and register load strobes from the two transfers; flush wins.
    always_comb begin
        w_stateNext    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;

        case (r_state)
            EMPTY: begin
                if (w_inXfer) begin
                    w_stateNext  = ONE;
                    w_loadMainIn = 1'b1;
                end
            end

            ONE: begin
                if (w_inXfer && !w_outXfer) begin
                    // Downstream stalled: park the new beat behind main.
                    w_stateNext = FULL;
                    w_loadSkid  = 1'b1;
                end else if (!w_inXfer && w_outXfer) begin
                    w_stateNext = EMPTY;
                end else if (w_inXfer && w_outXfer) begin
                    // Streaming: main is replaced in the same cycle it drains.
                    w_loadMainIn = 1'b1;
                end
            end

            FULL: begin
                // No input can arrive here because inReady is low.
                if (w_outXfer) begin
                    w_stateNext    = ONE;
                    w_loadMainSkid = 1'b1;
                end
            end

            default: begin
                w_stateNext = EMPTY;
            end
        endcase

        // Flush drops everything held and any beat offered this edge.
        // The main register keeps its last value so outData stays stable.
        if (bus.flush) begin
            w_stateNext    = EMPTY;
            w_loadMainIn   = 1'b0;
            w_loadMainSkid = 1'b0;
            w_loadSkid     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    //  Datapath registers
    // ------------------------------------------------------------------

    // Main and skid registers; each beat keeps its source tag alongside its data.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainIn) begin
                r_main <= w_inBeat;
            end else if (w_loadMainSkid) begin
                r_main <= r_skid;
            end

            if (w_loadSkid) begin
                r_skid <= w_inBeat;
            end
        end
    end

    // ------------------------------------------------------------------
    //  Per-source delivery counters (count on the out transfer, even on
    //  a flush edge; flush never clears them)
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cntA (
        .clock  (clock),
        .resetN (resetN),
        .inc    (w_outXfer && !r_main.sel),
        .value  (cntA)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cntB (
        .clock  (clock),
        .resetN (resetN),
        .inc    (w_outXfer && r_main.sel),
        .value  (cntB)
    );

endmodule : mux_result_skid_buffer
`default_nettype wire

// File: tb/tb_mux_result_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_mux_result_skid_buffer
//  Description: Self-checking bench for the mux result skid buffer. Two
//               instances (16-bit and 4-bit counters) see identical stimulus
//               and are compared every cycle against a queue-based model;
//               directed scenarios add literal expectations.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_mux_result_skid_buffer;

    localparam int DW  = 72;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    logic [CW-1:0]  cntA,  cntB;
    logic [CWS-1:0] cntAs, cntBs;

    mux_result_skid_buffer_if #(.DATA_W(DW)) bus  ();
    mux_result_skid_buffer_if #(.DATA_W(DW)) busS ();

    // The small-counter instance mirrors the main instance's inputs.
    assign busS.inValid  = bus.inValid;
    assign busS.inData   = bus.inData;
    assign busS.inSel    = bus.inSel;
    assign busS.flush    = bus.flush;
    assign busS.outReady = bus.outReady;

    mux_result_skid_buffer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave),
        .cntA   (cntA),
        .cntB   (cntB)
    );

    mux_result_skid_buffer #(.DATA_W(DW), .CNT_W(CWS)) dutSat (
        .clock  (clock),
        .resetN (resetN),
        .bus    (busS.slave),
        .cntA   (cntAs),
        .cntB   (cntBs)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    //  Bookkeeping
    // ------------------------------------------------------------------
    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    //  Behavioural model: a FIFO of capacity 2 holding {data, sel}
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic          sel;
    } mbeat_t;

    mbeat_t q[$];
    mbeat_t shown;      // last head value presented downstream
    int     nA;
    int     nB;

    function automatic int satTo(input int n, input int maxVal);
        return (n > maxVal) ? maxVal : n;
    endfunction

    task automatic modelReset();
        q.delete();
        shown.data = '0;
        shown.sel  = 1'b0;
        nA = 0;
        nB = 0;
    endtask

    task automatic modelStep();
        mbeat_t b;
        bit     canIn;
        bit     doOut;
        canIn = bus.inValid && (q.size() < 2);
        doOut = bus.outReady && (q.size() > 0);
        if (doOut) begin
            if (q[0].sel) nB++; else nA++;
            void'(q.pop_front());
        end
        if (bus.flush) begin
            q.delete();
        end else if (canIn) begin
            b.data = bus.inData;
            b.sel  = bus.inSel;
            q.push_back(b);
        end
        if (q.size() > 0) shown = q[0];
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clock or negedge resetN);
            if (!resetN) modelReset();
            else         modelStep();
        end
    end

    // Compare both instances against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("outValid", bus.outValid, q.size() > 0);
            check("inReady",  bus.inReady,  q.size() < 2);
            check("outData",  bus.outData,  shown.data);
            check("outSel",   bus.outSel,   shown.sel);
            check("cntA",     cntA, satTo(nA, (1 << CW) - 1));
            check("cntB",     cntB, satTo(nB, (1 << CW) - 1));
            check("sat_outData", busS.outData, shown.data);
            check("sat_cntA", cntAs, satTo(nA, (1 << CWS) - 1));
            check("sat_cntB", cntBs, satTo(nB, (1 << CWS) - 1));
        end
    end

    // ------------------------------------------------------------------
    //  Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inSel    = 1'b0;
        bus.flush    = 1'b0;
        bus.outReady = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        resetN = 1'b0;
        cycle();
        cycle();
        resetN = 1'b1;
        cycle();
    endtask

    task automatic push(input logic [DW-1:0] d, input logic s);
        bus.inValid = 1'b1;
        bus.inData  = d;
        bus.inSel   = s;
    endtask

    // ------------------------------------------------------------------
    //  Scenarios
    // ------------------------------------------------------------------
    logic [95:0] rnd;

    initial begin
        idleInputs();
        doReset();
        check("lit_reset_outValid", bus.outValid, 1'b0);
        check("lit_reset_inReady",  bus.inReady,  1'b1);

        // Single beat with downstream always ready.
        bus.outReady = 1'b1;
        push(72'h123456789ABCDEF123, 1'b0);
        cycle();
        bus.inValid = 1'b0;
        check("lit_single_outValid", bus.outValid, 1'b1);
        check("lit_single_outData",  bus.outData,  72'h123456789ABCDEF123);
        check("lit_single_outSel",   bus.outSel,   1'b0);
        cycle();
        check("lit_single_cntA",     cntA, 16'd1);
        check("lit_single_drained",  bus.outValid, 1'b0);

        // Backpressure: two beats fill the buffer, third is stalled.
        doReset();
        push('0, 1'b0);
        cycle();
        push({DW{1'b1}}, 1'b1);
        cycle();
        check("lit_bp_inReady_full", bus.inReady, 1'b0);
        push(72'h111111111111111111, 1'b1);
        cycle();
        cycle();
        check("lit_bp_head_held", bus.outData, 72'h0);
        check("lit_bp_still_full", bus.inReady, 1'b0);
        bus.outReady = 1'b1;
        cycle();
        check("lit_bp_second", bus.outData, {DW{1'b1}});
        cycle();
        bus.inValid = 1'b0;
        check("lit_bp_third", bus.outData, 72'h111111111111111111);
        cycle();
        check("lit_bp_cntA", cntA, 16'd1);
        check("lit_bp_cntB", cntB, 16'd2);

        // Asynchronous reset in the middle of a held beat.
        bus.outReady = 1'b0;
        push(72'h5555, 1'b0);
        cycle();
        bus.inValid = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        check("lit_async_outValid", bus.outValid, 1'b0);
        check("lit_async_inReady",  bus.inReady,  1'b1);
        check("lit_async_cntA",     cntA, 16'd0);
        check("lit_async_cntB",     cntB, 16'd0);
        cycle();
        resetN = 1'b1;
        cycle();

        // Back-to-back streaming of 8 alternating-tag beats.
        doReset();
        bus.outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(72'hA000 + 72'(i), i[0]);
            cycle();
            check("lit_stream_data",  bus.outData, 72'hA000 + 72'(i));
            check("lit_stream_ready", bus.inReady, 1'b1);
        end
        bus.inValid = 1'b0;
        cycle();
        check("lit_stream_cntA", cntA, 16'd4);
        check("lit_stream_cntB", cntB, 16'd4);

        // Flush while FULL with a new beat offered.
        doReset();
        push(72'hAAAA, 1'b0);
        cycle();
        push(72'hBBBB, 1'b1);
        cycle();
        push(72'hCCCC, 1'b0);
        bus.flush = 1'b1;
        cycle();
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        check("lit_flush_outValid", bus.outValid, 1'b0);
        check("lit_flush_inReady",  bus.inReady,  1'b1);
        check("lit_flush_hold",     bus.outData,  72'hAAAA);
        check("lit_flush_cntA",     cntA, 16'd0);
        check("lit_flush_cntB",     cntB, 16'd0);
        // Flush in ONE with a beat that would otherwise be accepted.
        push(72'hDDDD, 1'b1);
        cycle();
        push(72'hEEEE, 1'b1);
        bus.flush = 1'b1;
        cycle();
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        cycle();
        check("lit_flush_drop", bus.outValid, 1'b0);

        // Saturation on the 4-bit instance.
        doReset();
        bus.outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(72'(i), 1'b1);
            cycle();
        end
        bus.inValid = 1'b0;
        cycle();
        cycle();
        check("lit_sat_cntB",  cntBs, 4'd15);
        check("lit_sat_cntA",  cntAs, 4'd0);
        check("lit_wide_cntB", cntB,  16'd20);

        // Randomised traffic, first with light then heavy backpressure.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            bus.inValid  = ($urandom_range(0, 3) != 0);
            bus.inData   = rnd[DW-1:0];
            bus.inSel    = 1'($urandom_range(0, 1));
            bus.flush    = ($urandom_range(0, 40) == 0);
            bus.outReady = (i < 1500) ? ($urandom_range(0, 7) != 0)
                                      : ($urandom_range(0, 1) != 0);
            cycle();
        end
        idleInputs();
        bus.outReady = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_mux_result_skid_buffer
`default_nettype wire
